accel_sequencer: RTL and testbench
==================================

# accel_sequencer

Command sequencer between the software-facing operand RAM and the 1024-bit arithmetic core. It accepts one command at a time, loads operands A, B and M from the RAM's parallel output when software signals a complete block, and launches the core. It then writes the 1024-bit result back into the RAM and reports completion or timeout to the software-visible status bits.

## Interface
- DATA_WIDTH, 1024: operand and result width.
- TO_WIDTH, 16: watchdog counter width.
- TIMEOUT, 16'hFFFF: watchdog limit in cycles; 0 disables the watchdog.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset; clears all state.
- cmd  in  2  opcode: 0 LOAD_A, 1 LOAD_B, 2 LOAD_M, 3 EXEC.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse on successful command completion.
- error  out  1  sticky timeout flag.
- busy  out  1  state != IDLE.
- ram_dout  in  DATA_WIDTH  parallel RAM contents.
- ram_dout_valid  in  1  one-cycle pulse after software writes the last RAM word.
- ram_din  out  DATA_WIDTH  result to RAM.
- ram_din_we  out  1  RAM parallel write enable.
- ram_din_read  in  1  RAM acknowledge, one cycle after the accepted write.
- core_a, core_b, core_m  out  DATA_WIDTH each  registered operands.
- core_start  out  1  one-cycle start pulse.
- core_done  in  1  result valid strobe.
- core_result  in  DATA_WIDTH  core output.

## Operation
- States:
  - IDLE
  - WAIT_DATA
  - START
  - BUSY
  - WRITEBACK
  - WAIT_ACK
- IDLE:
  - A command is accepted when cmd_valid is high in IDLE. Accepting a command clears error.
  - cmd 0-2 go to WAIT_DATA.
  - cmd 3 goes to START.
  - cmd_valid outside IDLE is ignored. It is not queued.
- WAIT_DATA:
  - On ram_dout_valid, latch ram_dout into the operand register selected by the latched opcode.
  - Then pulse done and return to IDLE.
- START:
  - core_start=1 for exactly one cycle, then go to BUSY.
- BUSY:
  - On core_done, latch core_result into ram_din and go to WRITEBACK.
- WRITEBACK:
  - ram_din_we=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - On ram_din_read, pulse done and go to IDLE.
- Watchdog:
  - Counter runs in WAIT_DATA, BUSY and WAIT_ACK.
  - Cleared to 0 on every state transition.
  - Saturates at all-ones.
  - When TIMEOUT≠0 and count reaches TIMEOUT-1 without the awaited event: error←1, return to IDLE, no done pulse, operand registers unchanged.
- Simultaneous awaited event and timeout expiry in the same cycle: the event wins, no error.
- ram_dout_valid or core_done outside their waiting state: ignored.
- Operand registers hold their values across commands. EXEC reuses the last loaded A/B/M.
- Reset mid-operation:
  - Immediate return to IDLE.
  - core_start and ram_din_we drop asynchronously.
  - An in-flight core result is discarded.

## Timing
- Reset values:
  - state IDLE
  - cmd_ready=1
  - busy=0, done=0, error=0
  - ram_din_we=0, core_start=0
  - ram_din, core_a, core_b, core_m = 0
- All outputs are registered or decoded from state only. There is no combinational input→output path.
- LOAD latency: done is high the cycle after the ram_dout_valid cycle.
- EXEC:
  - core_start is high the cycle after acceptance.
  - ram_din_we is high the cycle after core_done.
  - done is high the cycle after ram_din_read.
  - Minimum EXEC length with a 1-cycle core is 6 cycles accept-to-done.
- cmd_ready is low from the cycle after acceptance until the cycle after done or timeout.

## Structure
- Shared package accel_pkg holds:
  - opcode constants CMD_LOAD_A/B/M, CMD_EXEC
  - state enum
  - DATA_WIDTH default
- Sub-module accel_watchdog holds the counter, clear, enable and expiry compare, parameterised by TO_WIDTH/TIMEOUT.
- The FSM and the operand/result registers stay in accel_sequencer.

## Test plan
- LOAD_A, then ram_dout=1024'h1234…, then ram_dout_valid: core_a=ram_dout, done pulses 1 cycle later, cmd_ready returns 1.
- LOAD A/B/M, then EXEC with a core model asserting core_done 3 cycles after core_start and core_result=1024'hDEAD: core_start pulses once, ram_din=1024'hDEAD with ram_din_we for 1 cycle, done after ram_din_read.
- TIMEOUT=8, EXEC, core never asserts done: error=1 exactly 8 cycles after entering BUSY, no done, no ram_din_we. The next accepted command clears error.
- cmd_valid held high during an EXEC with a different opcode: ignored, and core_a/core_b/core_m are unchanged when the EXEC completes.
- core_done arrives in the same cycle as timeout expiry: result is written back, error=0.
- reset asserted during WAIT_ACK: all outputs at reset values immediately, state IDLE, and a subsequent LOAD_B works normally.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator command sequencer: opcodes, FSM states, widths.
package accel_pkg;

  localparam int unsigned DATA_WIDTH = 1024;

  localparam logic [1:0] CMD_LOAD_A = 2'd0;
  localparam logic [1:0] CMD_LOAD_B = 2'd1;
  localparam logic [1:0] CMD_LOAD_M = 2'd2;
  localparam logic [1:0] CMD_EXEC   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_START,
    S_BUSY,
    S_WRITEBACK,
    S_WAIT_ACK
  } state_t;

endpackage

// File: rtl/accel_watchdog.sv
// Saturating cycle counter that flags expiry while the sequencer waits on an external event.
module accel_watchdog #(
  parameter int unsigned TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TIMEOUT - 1'b1;

  logic [TO_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry asserts during the last allowed cycle so the FSM leaves on the following edge.
  assign expired = enable && (TIMEOUT != '0) && (count == LIMIT);

endmodule

// File: rtl/accel_sequencer.sv
// Command sequencer: loads operands from the RAM, launches the core, writes the result back.
module accel_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = accel_pkg::DATA_WIDTH,
  parameter int unsigned TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  error,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_dout_valid,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_din_we,
  input  logic                  ram_din_read,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_b,
  output logic [DATA_WIDTH-1:0] core_m,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_result
);

  state_t     state;
  state_t     state_next;
  logic [1:0] op;
  logic       expired;
  logic       accept;
  logic       load_fire;
  logic       result_fire;
  logic       ack_fire;
  logic       timeout;

  assign accept      = (state == S_IDLE) && cmd_valid;
  assign load_fire   = (state == S_WAIT_DATA) && ram_dout_valid;
  assign result_fire = (state == S_BUSY) && core_done;
  assign ack_fire    = (state == S_WAIT_ACK) && ram_din_read;
  // The awaited event takes priority over a watchdog expiry in the same cycle.
  assign timeout     = expired && !(load_fire || result_fire || ack_fire);

  accel_watchdog #(
    .TO_WIDTH (TO_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_next != state),
    .enable  ((state == S_WAIT_DATA) || (state == S_BUSY) || (state == S_WAIT_ACK)),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (cmd_valid) state_next = (cmd == CMD_EXEC) ? S_START : S_WAIT_DATA;
      S_WAIT_DATA: if (load_fire || timeout) state_next = S_IDLE;
      S_START:     state_next = S_BUSY;
      S_BUSY: begin
        if (result_fire)  state_next = S_WRITEBACK;
        else if (timeout) state_next = S_IDLE;
      end
      S_WRITEBACK: state_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (ack_fire || timeout) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op      <= CMD_LOAD_A;
      done    <= 1'b0;
      error   <= 1'b0;
      core_a  <= '0;
      core_b  <= '0;
      core_m  <= '0;
      ram_din <= '0;
    end else begin
      state <= state_next;
      done  <= load_fire || ack_fire;
      if (accept) begin
        op    <= cmd;
        error <= 1'b0;
      end else if (timeout) begin
        error <= 1'b1;
      end
      if (load_fire) begin
        case (op)
          CMD_LOAD_A: core_a <= ram_dout;
          CMD_LOAD_B: core_b <= ram_dout;
          CMD_LOAD_M: core_m <= ram_dout;
          default:    ;
        endcase
      end
      if (result_fire) ram_din <= core_result;
    end
  end

  // Strobes decode from state so that reset removes them without waiting for a clock.
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign core_start = (state == S_START);
  assign ram_din_we = (state == S_WRITEBACK);

endmodule

// File: tb/tb_accel_sequencer.sv
// Scoreboard bench for accel_sequencer with a delay-programmable core model and TIMEOUT=8.
module tb_accel_sequencer;

  localparam int W = 1024;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   cmd = 2'd0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready, done, error, busy;
  logic [W-1:0] ram_dout = '0;
  logic         ram_dout_valid = 1'b0;
  logic [W-1:0] ram_din;
  logic         ram_din_we;
  logic         ram_din_read = 1'b0;
  logic [W-1:0] core_a, core_b, core_m;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [W-1:0] core_result = '0;

  typedef struct {
    int           kind;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] ma = '0, mb = '0, mm = '0;

  int           core_delay = 0;
  logic [W-1:0] core_value = '0;
  int           core_cnt = -1;

  accel_sequencer #(
    .TIMEOUT (16'd8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .done           (done),
    .error          (error),
    .busy           (busy),
    .ram_dout       (ram_dout),
    .ram_dout_valid (ram_dout_valid),
    .ram_din        (ram_din),
    .ram_din_we     (ram_din_we),
    .ram_din_read   (ram_din_read),
    .core_a         (core_a),
    .core_b         (core_b),
    .core_m         (core_m),
    .core_start     (core_start),
    .core_done      (core_done),
    .core_result    (core_result)
  );

  always #5 clk = ~clk;

  // Core model: core_done pulses core_delay cycles after the core_start cycle; 0 means never.
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (reset) begin
      core_cnt = -1;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done   = 1'b1;
          core_result = core_value;
          core_cnt    = -1;
        end
      end
      if (core_start && core_delay > 0) core_cnt = core_delay;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [W-1:0] val);
    exp_t e;
    logic [W-1:0] got;
    cmd = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tests++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL load_accept: ready=%b busy=%b error=%b done=%b, required 0 1 0 0",
               cmd_ready, busy, error, done);
    end
    e.kind = int'(op);
    e.val  = val;
    sb.push_back(e);
    case (op)
      2'd0: ma = val;
      2'd1: mb = val;
      default: mm = val;
    endcase
    ram_dout = val;
    ram_dout_valid = 1'b1;
    tick();
    ram_dout_valid = 1'b0;
    ram_dout = {32{$urandom()}};
    tests++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_done: done=%b ready=%b, required 1 1", done, cmd_ready);
    end
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0: got = core_a;
        1: got = core_b;
        default: got = core_m;
      endcase
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL load_value op%0d: got ..%h, required ..%h", e.kind, got[127:0], e.val[127:0]);
      end
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL load_done_width: done=%b, required 0", done);
    end
  endtask

  // Runs one EXEC; cycle numbers count from the acceptance cycle as 0.
  task automatic run_exec(input int delay, input logic [W-1:0] res, input bit hold,
                          output int starts, output int wes, output int we_c,
                          output int done_c, output int err_c);
    exp_t e;
    bit   pend;
    int   cyc;
    core_delay = delay;
    core_value = res;
    if (delay > 0 && delay <= TO) begin
      e.kind = 3;
      e.val  = res;
      sb.push_back(e);
    end
    cmd = 2'd3;
    cmd_valid = 1'b1;
    tick();
    starts = core_start ? 1 : 0;
    if (hold) cmd = 2'd0;
    else cmd_valid = 1'b0;
    wes = 0; we_c = -1; done_c = -1; err_c = -1; pend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hold) begin
        ram_dout = {32{$urandom()}};
        ram_dout_valid = i[0];
      end
      tick();
      cyc = i + 2;
      ram_din_read = pend;
      pend = 1'b0;
      if (core_start) starts++;
      if (ram_din_we) begin
        wes++;
        we_c = cyc;
        pend = 1'b1;
        cmd_valid = 1'b0;
        ram_dout_valid = 1'b0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL exec_unexpected_writeback: ram_din_we=1, required 0");
        end else begin
          e = sb.pop_front();
          if (ram_din !== e.val) begin
            fails++;
            $display("FAIL exec_result: ram_din=..%h, required ..%h", ram_din[127:0], e.val[127:0]);
          end
        end
      end
      if (done) begin
        done_c = cyc;
        break;
      end
      if (error) begin
        err_c = cyc;
        break;
      end
    end
    cmd_valid = 1'b0;
    ram_dout_valid = 1'b0;
    ram_din_read = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        ram_din_we !== 1'b0 || core_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b error=%b we=%b start=%b, required 1 0 0 0 0 0",
               cmd_ready, busy, done, error, ram_din_we, core_start);
    end
    tests++;
    if (ram_din !== '0 || core_a !== '0 || core_b !== '0 || core_m !== '0) begin
      fails++;
      $display("FAIL reset_data: din=..%h a=..%h b=..%h m=..%h, required 0",
               ram_din[63:0], core_a[63:0], core_b[63:0], core_m[63:0]);
    end
  endtask

  task automatic test_load();
    logic [W-1:0] v;
    v = {32{32'h12345678}};
    do_load(2'd0, v);
    do_load(2'd1, {16{64'hA5A5_0F0F_C3C3_9696}});
    do_load(2'd2, {W{1'b1}} >> 3);
    tests++;
    if (core_a !== ma || core_b !== mb || core_m !== mm) begin
      fails++;
      $display("FAIL load_hold: a=..%h b=..%h m=..%h, required ..%h ..%h ..%h",
               core_a[63:0], core_b[63:0], core_m[63:0], ma[63:0], mb[63:0], mm[63:0]);
    end
  endtask

  task automatic test_exec();
    int starts, wes, we_c, done_c, err_c;
    run_exec(3, W'(16'hDEAD), 1'b0, starts, wes, we_c, done_c, err_c);
    tests++;
    if (starts != 1 || wes != 1) begin
      fails++;
      $display("FAIL exec_pulses: starts=%0d writes=%0d, required 1 1", starts, wes);
    end
    tests++;
    if (we_c != 5 || done_c != 7 || err_c != -1) begin
      fails++;
      $display("FAIL exec_timing: we@%0d done@%0d err@%0d, required 5 7 -1", we_c, done_c, err_c);
    end
    tick();
    tests++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL exec_after: done=%b ready=%b error=%b, required 0 1 0", done, cmd_ready, error);
    end
  endtask

  task automatic test_ignore_cmd();
    int starts, wes, we_c, done_c, err_c;
    run_exec(3, {8{128'hBEEF_0000_1111_2222}}, 1'b1, starts, wes, we_c, done_c, err_c);
    tests++;
    if (we_c != 5 || done_c != 7 || starts != 1) begin
      fails++;
      $display("FAIL ignore_timing: we@%0d done@%0d starts=%0d, required 5 7 1", we_c, done_c, starts);
    end
    tests++;
    if (core_a !== ma || core_b !== mb || core_m !== mm) begin
      fails++;
      $display("FAIL ignore_operands: a=..%h b=..%h m=..%h, required ..%h ..%h ..%h",
               core_a[63:0], core_b[63:0], core_m[63:0], ma[63:0], mb[63:0], mm[63:0]);
    end
  endtask

  task automatic test_timeout();
    int starts, wes, we_c, done_c, err_c;
    run_exec(0, '0, 1'b0, starts, wes, we_c, done_c, err_c);
    tests++;
    if (err_c != 10 || done_c != -1 || wes != 0 || starts != 1) begin
      fails++;
      $display("FAIL timeout_timing: err@%0d done@%0d writes=%0d starts=%0d, required 10 -1 0 1",
               err_c, done_c, wes, starts);
    end
    repeat (3) tick();
    tests++;
    if (error !== 1'b1 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL timeout_sticky: error=%b ready=%b done=%b, required 1 1 0", error, cmd_ready, done);
    end
    tests++;
    if (core_a !== ma || core_b !== mb || core_m !== mm) begin
      fails++;
      $display("FAIL timeout_operands: a=..%h, required ..%h", core_a[63:0], ma[63:0]);
    end
    do_load(2'd0, {32{32'hCAFE_F00D}});
  endtask

  task automatic test_race();
    int starts, wes, we_c, done_c, err_c;
    run_exec(TO, {4{256'h5555_AAAA_1357_9BDF}}, 1'b0, starts, wes, we_c, done_c, err_c);
    tests++;
    if (we_c != 10 || done_c != 12 || err_c != -1 || wes != 1) begin
      fails++;
      $display("FAIL race_timing: we@%0d done@%0d err@%0d writes=%0d, required 10 12 -1 1",
               we_c, done_c, err_c, wes);
    end
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL race_error: error=%b, required 0", error);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    core_delay = 3;
    core_value = W'(64'h0123_4567_89AB_CDEF);
    e.kind = 3;
    e.val = core_value;
    sb.push_back(e);
    cmd = 2'd3;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ram_din_we) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rst_mid_writeback: ram_din_we never seen, required within 20 cycles");
    end else begin
      e = sb.pop_front();
      if (ram_din !== e.val) begin
        fails++;
        $display("FAIL rst_mid_writeback: ram_din=..%h, required ..%h", ram_din[63:0], e.val[63:0]);
      end
    end
    tick();
    tests++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_waitack: busy=%b ready=%b, required 1 0", busy, cmd_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    ma = '0; mb = '0; mm = '0;
    test_reset();
    #2;
    reset = 1'b0;
    tick();
    do_load(2'd1, {32{32'h0BAD_BEEF}});
    tests++;
    if (core_a !== '0 || core_m !== '0 || core_b !== mb) begin
      fails++;
      $display("FAIL rst_mid_reload: a=..%h b=..%h m=..%h, required 0 ..%h 0",
               core_a[63:0], core_b[63:0], core_m[63:0], mb[63:0]);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    test_reset();
    test_load();
    test_exec();
    test_ignore_cmd();
    test_timeout();
    test_race();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
